// File: rtl/dmem_access_unit.sv
// dmem_access_unit
//
// Memory-stage data access unit. Sits behind the EX/MEM pipeline register,
// decodes the load/store codes, and runs one word-wide request/acknowledge
// transaction to data memory per access. BUSY_WAIT stalls the pipeline until
// the access finishes; load results are extracted and extended into READ_DATA.
//
// Ports
//   CLK, RESET          clock, asynchronous active-high reset
//   MEM_READ[2:0]       load code  (1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, else none)
//   MEM_WRITE[2:0]      store code (1 SB, 2 SH, 3 SW, else none)
//   ADDRESS[31:0]       byte address
//   WRITE_DATA[31:0]    store data (unshifted)
//   READ_DATA[31:0]     extended load result, held until the next load completes
//   BUSY_WAIT           stall request to the pipeline registers
//   MISALIGNED          current request is misaligned (no access is made)
//   BUS_ERROR           one-cycle pulse when an access times out
//   MEM_REQ_READ/WRITE  memory request strobes, high until the ACK cycle
//   MEM_ADDR[29:0]      word address
//   MEM_WDATA[31:0]     lane-placed store data
//   MEM_BYTE_EN[3:0]    byte-lane enables
//   MEM_RDATA[31:0]     read word from memory
//   MEM_ACK             memory completion, one cycle
//   STATE_DBG[1:0]      current FSM state (0 IDLE, 1 RD_WAIT, 2 WR_WAIT, 3 DONE)
//
// Handshake: a request is held on MEM_REQ_* with MEM_ADDR/MEM_WDATA/
// MEM_BYTE_EN stable from the edge leaving IDLE until the cycle in which
// MEM_ACK is seen high; MEM_ACK outside a WAIT state carries no meaning.
module dmem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [2:0]  MEM_READ,
  input  logic [2:0]  MEM_WRITE,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] WRITE_DATA,
  output logic [31:0] READ_DATA,
  output logic        BUSY_WAIT,
  output logic        MISALIGNED,
  output logic        BUS_ERROR,
  output logic        MEM_REQ_READ,
  output logic        MEM_REQ_WRITE,
  output logic [29:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  output logic [3:0]  MEM_BYTE_EN,
  input  logic [31:0] MEM_RDATA,
  input  logic        MEM_ACK,
  output logic [1:0]  STATE_DBG
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic        req_rd_q, req_rd_d;
  logic        req_wr_q, req_wr_d;
  logic        bus_err_q, bus_err_d;
  logic [29:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [2:0]  ld_code_q, ld_code_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] word_q, word_d;
  logic [31:0] read_data_q, read_data_d;

  // Request decode
  logic st_valid, ld_valid, req_valid;
  logic is_half, is_word, misaligned, go;

  // Pick the addressed byte/halfword out of a word and extend it.
  function automatic logic [31:0] extend_load(input logic [31:0] word,
                                              input logic [2:0]  code,
                                              input logic [1:0]  off);
    logic [31:0] bsh;
    logic [31:0] hsh;
    bsh = word >> {off, 3'b000};
    hsh = word >> {off[1], 4'b0000};
    case (code)
      3'd1:    extend_load = {{24{bsh[7]}}, bsh[7:0]};
      3'd2:    extend_load = {{16{hsh[15]}}, hsh[15:0]};
      3'd4:    extend_load = {24'b0, bsh[7:0]};
      3'd5:    extend_load = {16'b0, hsh[15:0]};
      default: extend_load = word;
    endcase
  endfunction

  always_comb begin
    st_valid  = (MEM_WRITE == 3'd1) || (MEM_WRITE == 3'd2) || (MEM_WRITE == 3'd3);
    ld_valid  = (MEM_READ >= 3'd1) && (MEM_READ <= 3'd5);
    req_valid = st_valid || ld_valid;
    // Access size comes from the store when one is present (store wins).
    if (st_valid) begin
      is_half = (MEM_WRITE == 3'd2);
      is_word = (MEM_WRITE == 3'd3);
    end else begin
      is_half = (MEM_READ == 3'd2) || (MEM_READ == 3'd5);
      is_word = (MEM_READ == 3'd3);
    end
    misaligned = req_valid && ((is_half && ADDRESS[0]) ||
                               (is_word && (ADDRESS[1:0] != 2'b00)));
    go = req_valid && !misaligned;
  end

  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_rd_d    = req_rd_q;
    req_wr_d    = req_wr_q;
    bus_err_d   = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    ld_code_d   = ld_code_q;
    off_d       = off_q;
    word_d      = word_q;
    read_data_d = read_data_q;

    case (state_q)
      IDLE: begin
        if (go) begin
          cnt_d     = '0;
          addr_d    = ADDRESS[31:2];
          off_d     = ADDRESS[1:0];
          ld_code_d = MEM_READ;
          if (st_valid) begin
            state_d  = WR_WAIT;
            req_wr_d = 1'b1;
            case (MEM_WRITE)
              3'd1: begin
                be_d    = 4'b0001 << ADDRESS[1:0];
                wdata_d = {24'b0, WRITE_DATA[7:0]} << {ADDRESS[1:0], 3'b000};
              end
              3'd2: begin
                be_d    = ADDRESS[1] ? 4'b1100 : 4'b0011;
                wdata_d = {16'b0, WRITE_DATA[15:0]} << {ADDRESS[1], 4'b0000};
              end
              default: begin
                be_d    = 4'b1111;
                wdata_d = WRITE_DATA;
              end
            endcase
          end else begin
            state_d  = RD_WAIT;
            req_rd_d = 1'b1;
            be_d     = 4'b1111;
            wdata_d  = 32'b0;
          end
        end
      end

      RD_WAIT, WR_WAIT: begin
        if (MEM_ACK) begin
          state_d  = DONE;
          req_rd_d = 1'b0;
          req_wr_d = 1'b0;
          if (state_q == RD_WAIT) begin
            word_d      = MEM_RDATA;
            read_data_d = extend_load(MEM_RDATA, ld_code_q, off_q);
          end
        end else if (cnt_inc == CW'(TIMEOUT_CYCLES)) begin
          // Abort: the load word and READ_DATA keep their old values.
          state_d   = DONE;
          req_rd_d  = 1'b0;
          req_wr_d  = 1'b0;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      // One-cycle gap so the request still on the inputs is not re-issued
      // before the pipeline advances.
      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_rd_q    <= 1'b0;
      req_wr_q    <= 1'b0;
      bus_err_q   <= 1'b0;
      addr_q      <= 30'b0;
      wdata_q     <= 32'b0;
      be_q        <= 4'b0;
      ld_code_q   <= 3'b0;
      off_q       <= 2'b0;
      word_q      <= 32'b0;
      read_data_q <= 32'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_rd_q    <= req_rd_d;
      req_wr_q    <= req_wr_d;
      bus_err_q   <= bus_err_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      ld_code_q   <= ld_code_d;
      off_q       <= off_d;
      word_q      <= word_d;
      read_data_q <= read_data_d;
    end
  end

  assign BUSY_WAIT     = ((state_q == IDLE) && go) ||
                         (state_q == RD_WAIT) || (state_q == WR_WAIT);
  assign MISALIGNED    = misaligned;
  assign BUS_ERROR     = bus_err_q;
  assign MEM_REQ_READ  = req_rd_q;
  assign MEM_REQ_WRITE = req_wr_q;
  assign MEM_ADDR      = addr_q;
  assign MEM_WDATA     = wdata_q;
  assign MEM_BYTE_EN   = be_q;
  assign READ_DATA     = read_data_q;
  assign STATE_DBG     = state_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
module tb_dmem_access_unit;

  localparam logic [31:0] S_IDLE = 32'd0;
  localparam logic [31:0] S_RD   = 32'd1;
  localparam logic [31:0] S_WR   = 32'd2;
  localparam logic [31:0] S_DONE = 32'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  mem_read, mem_write;
  logic [31:0] address, write_data;
  logic [31:0] read_data;
  logic        busy_wait, misaligned, bus_error;
  logic        mem_req_read, mem_req_write;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  // Monitor counts, sampled on the falling edge
  int busy_cycles = 0;
  int rd_req_rises = 0;
  logic prev_req_rd = 1'b0;

  dmem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .CLK(clk), .RESET(rst),
    .MEM_READ(mem_read), .MEM_WRITE(mem_write),
    .ADDRESS(address), .WRITE_DATA(write_data),
    .READ_DATA(read_data), .BUSY_WAIT(busy_wait),
    .MISALIGNED(misaligned), .BUS_ERROR(bus_error),
    .MEM_REQ_READ(mem_req_read), .MEM_REQ_WRITE(mem_req_write),
    .MEM_ADDR(mem_addr), .MEM_WDATA(mem_wdata), .MEM_BYTE_EN(mem_byte_en),
    .MEM_RDATA(mem_rdata), .MEM_ACK(mem_ack), .STATE_DBG(state_dbg)
  );

  // Clock / timeout guard
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (busy_wait) busy_cycles = busy_cycles + 1;
    if (mem_req_read && !prev_req_rd) rd_req_rises = rd_req_rises + 1;
    prev_req_rd = mem_req_read;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Driver tasks; each returns 1ns after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request in IDLE and move to the first WAIT cycle.
  task automatic start_access(input logic [2:0] rd, input logic [2:0] wr,
                              input logic [31:0] addr, input logic [31:0] wd);
    mem_read   = rd;
    mem_write  = wr;
    address    = addr;
    write_data = wd;
    step();
  endtask

  // ACK in WAIT cycle (1 + extra); returns in DONE.
  task automatic ack_access(input int extra, input logic [31:0] rdata);
    repeat (extra) step();
    mem_ack   = 1'b1;
    mem_rdata = rdata;
    step();
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
  endtask

  // Leave DONE; pipeline advances and the request goes away.
  task automatic finish_access();
    step();
    mem_read  = 3'd0;
    mem_write = 3'd0;
  endtask

  task automatic do_load(input logic [2:0] code, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [31:0] exp, input string tag);
    start_access(code, 3'd0, addr, 32'h0);
    ack_access(0, rdata);
    check({tag, "_state_done"}, {30'b0, state_dbg}, S_DONE);
    check({tag, "_read_data"}, read_data, exp);
    finish_access();
  endtask

  int b0, r0;

  initial begin
    rst = 1'b1;
    mem_read = 3'd0; mem_write = 3'd0;
    address = 32'h0; write_data = 32'h0;
    mem_rdata = 32'h0; mem_ack = 1'b0;
    #1;
    // Reset state
    check("rst_state", {30'b0, state_dbg}, S_IDLE);
    check("rst_read_data", read_data, 32'h0);
    check("rst_req_rd", {31'b0, mem_req_read}, 32'd0);
    check("rst_req_wr", {31'b0, mem_req_write}, 32'd0);
    check("rst_addr", {2'b0, mem_addr}, 32'h0);
    check("rst_be", {28'b0, mem_byte_en}, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_bus_err", {31'b0, bus_error}, 32'd0);
    check("rst_busy", {31'b0, busy_wait}, 32'd0);
    step(); step();
    rst = 1'b0;
    step();

    // LW 0x100, ACK in second wait cycle
    b0 = busy_cycles; r0 = rd_req_rises;
    mem_read = 3'd3; address = 32'h100;
    #1;
    check("lw_busy_idle", {31'b0, busy_wait}, 32'd1);
    check("lw_misaligned", {31'b0, misaligned}, 32'd0);
    step();
    check("lw_state_rd", {30'b0, state_dbg}, S_RD);
    check("lw_req_rd", {31'b0, mem_req_read}, 32'd1);
    check("lw_req_wr", {31'b0, mem_req_write}, 32'd0);
    check("lw_addr", {2'b0, mem_addr}, 32'h40);
    check("lw_be", {28'b0, mem_byte_en}, 32'hF);
    ack_access(1, 32'h8000_00F1);
    check("lw_state_done", {30'b0, state_dbg}, S_DONE);
    check("lw_busy_done", {31'b0, busy_wait}, 32'd0);
    check("lw_req_rd_drop", {31'b0, mem_req_read}, 32'd0);
    check("lw_read_data", read_data, 32'h8000_00F1);
    finish_access();
    check("lw_state_idle", {30'b0, state_dbg}, S_IDLE);
    step();
    check("lw_busy_cycles", busy_cycles - b0, 32'd3);
    check("lw_req_pulses", rd_req_rises - r0, 32'd1);

    // Sub-word loads with extension
    do_load(3'd1, 32'h103, 32'hF122_3344, 32'hFFFF_FFF1, "lb");
    do_load(3'd4, 32'h103, 32'hF122_3344, 32'h0000_00F1, "lbu");
    do_load(3'd2, 32'h102, 32'h8001_1234, 32'hFFFF_8001, "lh");
    do_load(3'd5, 32'h100, 32'h1234_8765, 32'h0000_8765, "lhu");
    do_load(3'd1, 32'h101, 32'h0000_7F00, 32'h0000_007F, "lb_pos");

    // SH to 0x202 with a load also present: store wins
    start_access(3'd3, 3'd2, 32'h202, 32'h1234_ABCD);
    check("sh_state_wr", {30'b0, state_dbg}, S_WR);
    check("sh_req_wr", {31'b0, mem_req_write}, 32'd1);
    check("sh_no_req_rd", {31'b0, mem_req_read}, 32'd0);
    check("sh_addr", {2'b0, mem_addr}, 32'h80);
    check("sh_be", {28'b0, mem_byte_en}, 32'hC);
    check("sh_wdata", mem_wdata, 32'hABCD_0000);
    check("sh_busy", {31'b0, busy_wait}, 32'd1);
    step();
    check("sh_wdata_hold", mem_wdata, 32'hABCD_0000);
    ack_access(0, 32'hDEAD_BEEF);
    check("sh_state_done", {30'b0, state_dbg}, S_DONE);
    check("sh_req_wr_drop", {31'b0, mem_req_write}, 32'd0);
    check("sh_read_data_kept", read_data, 32'h0000_007F);
    finish_access();

    // SB to 0x201, SW to 0x204
    start_access(3'd0, 3'd1, 32'h201, 32'h0000_005A);
    check("sb_be", {28'b0, mem_byte_en}, 32'h2);
    check("sb_wdata", mem_wdata, 32'h0000_5A00);
    ack_access(0, 32'h0);
    finish_access();
    start_access(3'd0, 3'd3, 32'h204, 32'hCAFE_F00D);
    check("sw_addr", {2'b0, mem_addr}, 32'h81);
    check("sw_be", {28'b0, mem_byte_en}, 32'hF);
    check("sw_wdata", mem_wdata, 32'hCAFE_F00D);
    ack_access(0, 32'h0);
    finish_access();

    // Misaligned LW and SH stay in IDLE with no request
    mem_read = 3'd3; address = 32'h102;
    #1;
    check("mis_lw_flag", {31'b0, misaligned}, 32'd1);
    check("mis_lw_busy", {31'b0, busy_wait}, 32'd0);
    step();
    check("mis_lw_state", {30'b0, state_dbg}, S_IDLE);
    check("mis_lw_req", {31'b0, mem_req_read}, 32'd0);
    mem_read = 3'd0; mem_write = 3'd2; address = 32'h203;
    #1;
    check("mis_sh_flag", {31'b0, misaligned}, 32'd1);
    step();
    check("mis_sh_req", {31'b0, mem_req_write}, 32'd0);
    check("mis_read_data", read_data, 32'h0000_007F);
    mem_write = 3'd0;
    #1;
    check("mis_clear", {31'b0, misaligned}, 32'd0);

    // ACK in IDLE is ignored
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    step();
    mem_ack = 1'b0;
    check("idle_ack_state", {30'b0, state_dbg}, S_IDLE);
    check("idle_ack_read_data", read_data, 32'h0000_007F);

    // Timeout after 4 wait cycles
    mem_rdata = 32'h5555_5555;
    start_access(3'd3, 3'd0, 32'h104, 32'h0);
    repeat (3) step();
    check("to_state_w4", {30'b0, state_dbg}, S_RD);
    check("to_no_err_yet", {31'b0, bus_error}, 32'd0);
    step();
    check("to_state_done", {30'b0, state_dbg}, S_DONE);
    check("to_bus_err", {31'b0, bus_error}, 32'd1);
    check("to_busy_done", {31'b0, busy_wait}, 32'd0);
    check("to_req_drop", {31'b0, mem_req_read}, 32'd0);
    check("to_read_data", read_data, 32'h0000_007F);
    finish_access();
    check("to_err_pulse", {31'b0, bus_error}, 32'd0);
    check("to_idle", {30'b0, state_dbg}, S_IDLE);

    // Reset during RD_WAIT, then a late ACK
    start_access(3'd3, 3'd0, 32'h108, 32'h0);
    check("rr_state_rd", {30'b0, state_dbg}, S_RD);
    rst = 1'b1;
    #1;
    check("rr_state_idle", {30'b0, state_dbg}, S_IDLE);
    check("rr_req_drop", {31'b0, mem_req_read}, 32'd0);
    check("rr_read_data", read_data, 32'h0);
    step();
    rst = 1'b0;
    mem_read = 3'd0;
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_0001;
    step();
    mem_ack = 1'b0;
    check("rr_late_ack_data", read_data, 32'h0);
    check("rr_late_ack_state", {30'b0, state_dbg}, S_IDLE);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
